// File: rtl/rdp_systolic_xor_stage_if.sv
// Handshake bundle between the stripe distributor, the RDP XOR stage and the parity writer.
// Carries i_par only when RDP_SYSTOLIC_XOR_PARITY_EN is defined.
interface rdp_systolic_xor_stage_if #(
  parameter int DW   = 512,
  parameter int NGRP = 2,
  parameter int GSZ  = 2
);
  logic                     mode;
  logic [NGRP*GSZ*DW-1:0]   t_k_dat;
  logic [DW-1:0]            t_c_dat;
  logic                     t_valid;
  logic                     t_last;
  logic                     t_ready;
  logic [NGRP*DW-1:0]       i_dat;
  logic                     i_valid;
  logic                     i_ready;
`ifdef RDP_SYSTOLIC_XOR_PARITY_EN
  logic [NGRP-1:0]          i_par;

  modport master (
    output mode, t_k_dat, t_c_dat, t_valid, t_last, i_ready,
    input  t_ready, i_dat, i_valid, i_par
  );

  modport slave (
    input  mode, t_k_dat, t_c_dat, t_valid, t_last, i_ready,
    output t_ready, i_dat, i_valid, i_par
  );
`else
  modport master (
    output mode, t_k_dat, t_c_dat, t_valid, t_last, i_ready,
    input  t_ready, i_dat, i_valid
  );

  modport slave (
    input  mode, t_k_dat, t_c_dat, t_valid, t_last, i_ready,
    output t_ready, i_dat, i_valid
  );
`endif
endinterface

// File: rtl/rdp_systolic_xor_stage.sv
// RDP systolic XOR combiner: per-group lane XOR plus common term, multi-beat accumulate, 2-entry output FIFO.
// Optional per-group parity output enabled by defining RDP_SYSTOLIC_XOR_PARITY_EN.
module rdp_systolic_xor_stage #(
  parameter int DW   = 512,
  parameter int NGRP = 2,
  parameter int GSZ  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  rdp_systolic_xor_stage_if.slave bus
);

  localparam int WW = NGRP * DW;

  function automatic logic [WW-1:0] beat_term(
    input logic [NGRP*GSZ*DW-1:0] k,
    input logic [DW-1:0]          c
  );
    logic [WW-1:0] r;
    for (int g = 0; g < NGRP; g++) begin
      r[g*DW +: DW] = c;
      for (int j = 0; j < GSZ; j++) begin
        r[g*DW +: DW] = r[g*DW +: DW] ^ k[(g*GSZ+j)*DW +: DW];
      end
    end
    return r;
  endfunction

`ifdef RDP_SYSTOLIC_XOR_PARITY_EN
  function automatic logic [NGRP-1:0] group_parity(input logic [WW-1:0] w);
    logic [NGRP-1:0] p;
    for (int g = 0; g < NGRP; g++) begin
      p[g] = ^w[g*DW +: DW];
    end
    return p;
  endfunction
`endif

  logic [1:0]    count_p1;
  logic          wr_ptr_p1;
  logic          rd_ptr_p1;
  logic [WW-1:0] mem_p1 [2];
  logic [WW-1:0] head_p1;
  logic [WW-1:0] acc_p1;
  logic          busy_p1;
  logic          stripe_mode_p1;

  logic [WW-1:0] beat_p0;
  logic [WW-1:0] push_word_p0;
  logic          accept_p0;
  logic          eff_mode_p0;
  logic          push_p0;
  logic          pop_p0;
  logic          head_load_push_p0;
  logic          head_load_next_p0;

  // ---- stage p0: beat combine and handshake decode ----
  assign beat_p0      = beat_term(bus.t_k_dat, bus.t_c_dat);
  assign push_word_p0 = busy_p1 ? (acc_p1 ^ beat_p0) : beat_p0;

  assign bus.t_ready  = (count_p1 != 2'd2);
  assign bus.i_valid  = (count_p1 != 2'd0);
  assign bus.i_dat    = head_p1;

  assign accept_p0    = bus.t_valid & bus.t_ready;
  // Mode is sampled once per stripe; mid-stripe changes must not end it early.
  assign eff_mode_p0  = busy_p1 ? stripe_mode_p1 : bus.mode;
  assign push_p0      = accept_p0 & (~eff_mode_p0 | bus.t_last);
  assign pop_p0       = bus.i_valid & bus.i_ready;

  // The output register follows the FIFO head so i_dat never needs a read mux.
  assign head_load_push_p0 = push_p0 & ((count_p1 == 2'd0) | ((count_p1 == 2'd1) & pop_p0));
  assign head_load_next_p0 = pop_p0 & (count_p1 == 2'd2);

  // ---- stage p1: accumulator, FIFO storage and registered head ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p1         <= '0;
      busy_p1        <= 1'b0;
      stripe_mode_p1 <= 1'b0;
    end else if (accept_p0) begin
      if (!busy_p1) stripe_mode_p1 <= bus.mode;
      if (push_p0) begin
        acc_p1  <= '0;
        busy_p1 <= 1'b0;
      end else begin
        acc_p1  <= acc_p1 ^ beat_p0;
        busy_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_p1  <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      head_p1   <= '0;
      for (int i = 0; i < 2; i++) mem_p1[i] <= '0;
    end else begin
      if (push_p0) begin
        mem_p1[wr_ptr_p1] <= push_word_p0;
        wr_ptr_p1         <= ~wr_ptr_p1;
      end
      if (pop_p0) rd_ptr_p1 <= ~rd_ptr_p1;

      if (head_load_push_p0)      head_p1 <= push_word_p0;
      else if (head_load_next_p0) head_p1 <= mem_p1[~rd_ptr_p1];

      case ({push_p0, pop_p0})
        2'b10:   count_p1 <= count_p1 + 2'd1;
        2'b01:   count_p1 <= count_p1 - 2'd1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

`ifdef RDP_SYSTOLIC_XOR_PARITY_EN
  logic [NGRP-1:0] par_mem_p1 [2];
  logic [NGRP-1:0] head_par_p1;
  logic [NGRP-1:0] push_par_p0;

  assign push_par_p0 = group_parity(push_word_p0);
  assign bus.i_par   = head_par_p1;

  // ---- stage p1: parity side-store, same pointers as the data FIFO ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_par_p1 <= '0;
      for (int i = 0; i < 2; i++) par_mem_p1[i] <= '0;
    end else begin
      if (push_p0) par_mem_p1[wr_ptr_p1] <= push_par_p0;
      if (head_load_push_p0)      head_par_p1 <= push_par_p0;
      else if (head_load_next_p0) head_par_p1 <= par_mem_p1[~rd_ptr_p1];
    end
  end
`endif

endmodule
